// File: rtl/hot_page_addr_fetcher_mc.sv
// hot_page_addr_fetcher_mc
// Purpose: fetches src/dst PFN pair groups from a host ring over an AXI read
// channel. It holds up to two groups with out-of-order beat reassembly and hands
// each group to NUM_CHAN migration channels through a grp_valid/grp_ready
// handshake. In huge-page mode it generates consecutive 4 KiB pair groups
// arithmetically, with no memory reads.
// Ports:
//   axi4_mm_clk / axi4_mm_rst        clock, synchronous active-high reset
//   addr_pair_buf_pAddr, ring_groups ring base byte address (0 = off), depth
//   addr_pair_vld_cnt                cumulative groups posted by the host
//   huge_pg_start, huge_pg_addr_pair huge-page request pulse, {dst,src} PFN
//   csr_aruser                       AR user field
//   hppb_dst_ar*, hppb_dst_r*        AXI read address / read data channels
//   grp_valid, grp_ready             group handshake
//   src_addr, dst_addr, pair_vld     flattened payload; channel c, index i at
//                                    slot c*PER_CH+i (64 bits per address)
//   grp_done_cnt, rresp_err_cnt      group hand-offs, errored beats
//   busy                             any activity or pending request
module hot_page_addr_fetcher_mc #(
    parameter int NUM_CHAN      = 2,
    parameter int MIG_GRP_SIZE  = 16,
    parameter int HUGE_PG_PAIRS = 512
) (
    input  logic                         axi4_mm_clk,
    input  logic                         axi4_mm_rst,
    input  logic [63:0]                  addr_pair_buf_pAddr,
    input  logic [15:0]                  ring_groups,
    input  logic [63:0]                  addr_pair_vld_cnt,
    input  logic                         huge_pg_start,
    input  logic [63:0]                  huge_pg_addr_pair,
    input  logic [5:0]                   csr_aruser,
    output logic [11:0]                  hppb_dst_arid,
    output logic [63:0]                  hppb_dst_araddr,
    output logic                         hppb_dst_arvalid,
    output logic [5:0]                   hppb_dst_aruser,
    input  logic                         hppb_dst_arready,
    input  logic [11:0]                  hppb_dst_rid,
    input  logic [511:0]                 hppb_dst_rdata,
    input  logic [1:0]                   hppb_dst_rresp,
    input  logic                         hppb_dst_rvalid,
    output logic                         hppb_dst_rready,
    output logic                         grp_valid,
    input  logic                         grp_ready,
    output logic [64*MIG_GRP_SIZE-1:0]   src_addr,
    output logic [64*MIG_GRP_SIZE-1:0]   dst_addr,
    output logic [MIG_GRP_SIZE-1:0]      pair_vld,
    output logic [63:0]                  grp_done_cnt,
    output logic [31:0]                  rresp_err_cnt,
    output logic                         busy
);
    localparam int BEATS  = MIG_GRP_SIZE / 8;
    localparam int PER_CH = MIG_GRP_SIZE / NUM_CHAN;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NGRP   = HUGE_PG_PAIRS / MIG_GRP_SIZE;
    localparam int GW     = (NGRP > 1) ? $clog2(NGRP) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HUGE} state_t;
    state_t state, next_state;

    logic [62:0]       fetched_cnt;
    logic [15:0]       grp_ptr;
    logic [BW-1:0]     beat_cnt;
    logic [63:0]       fetch_base;
    logic              wr_slot;
    logic              rd_slot;
    logic [1:0]        slot_alloc;
    logic [BEATS-1:0]  slot_mask [2];
    logic [BEATS-1:0]  slot_ok [2];
    logic [511:0]      slot_data [2][BEATS];
    logic              huge_req;
    logic [31:0]       huge_src_pfn;
    logic [31:0]       huge_dst_pfn;
    logic [GW-1:0]     huge_g;

    logic [62:0]       pending;
    logic [1:0]        slot_full;
    logic              r_slot;
    logic [BW-1:0]     r_beat;
    logic              r_accept;
    logic              last_beat_acc;
    logic              hs;
    logic [16:0]       ptr_inc;
    logic [63:0]       beat_index;
    logic [63:0]       pair;
    logic [64*MIG_GRP_SIZE-1:0] nx_src;
    logic [64*MIG_GRP_SIZE-1:0] nx_dst;
    logic [MIG_GRP_SIZE-1:0]    nx_vld;
    logic              unused_bits;

    assign unused_bits = ^{addr_pair_vld_cnt[63], hppb_dst_rid[11:BW+1]};

    // Pending wraps modulo 2^63, matching the host's 63-bit doorbell counter.
    assign pending       = addr_pair_vld_cnt[62:0] - fetched_cnt;
    assign slot_full[0]  = &slot_mask[0];
    assign slot_full[1]  = &slot_mask[1];
    assign r_slot        = hppb_dst_rid[BW];
    assign r_beat        = hppb_dst_rid[BW-1:0];
    // Beats for a slot not waiting on data (e.g. stragglers from before a reset) are dropped.
    assign r_accept      = hppb_dst_rvalid && slot_alloc[r_slot] && !slot_full[r_slot];
    assign last_beat_acc = (state == ST_FETCH) && hppb_dst_arready && (beat_cnt == BW'(BEATS - 1));
    assign hs            = grp_valid && grp_ready;
    assign ptr_inc       = {1'b0, grp_ptr} + 17'd1;
    assign beat_index    = 64'(grp_ptr) * 64'(BEATS) + 64'(beat_cnt);

    assign hppb_dst_arvalid = (state == ST_FETCH);
    assign hppb_dst_araddr  = fetch_base + (beat_index << 6);
    assign hppb_dst_arid    = 12'({wr_slot, beat_cnt});
    assign hppb_dst_aruser  = csr_aruser;
    assign hppb_dst_rready  = 1'b1;
    assign busy             = (state != ST_IDLE) || (slot_alloc != 2'b00) || huge_req;

    // Huge mode only starts with both slots drained and no ring work queued,
    // so its groups never interleave with fetched groups.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (huge_req && (slot_alloc == 2'b00) && (pending == '0))
                    next_state = ST_HUGE;
                else if ((pending != '0) && (addr_pair_buf_pAddr != '0) && !slot_alloc[wr_slot])
                    next_state = ST_FETCH;
            end
            ST_FETCH: if (last_beat_acc) next_state = ST_IDLE;
            ST_HUGE:  if (hs && (huge_g == GW'(NGRP - 1))) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Next payload: group pair k lands on channel k % NUM_CHAN, index k / NUM_CHAN.
    always_comb begin
        nx_src = '0;
        nx_dst = '0;
        nx_vld = '0;
        pair   = '0;
        for (int k = 0; k < MIG_GRP_SIZE; k++) begin
            if (state == ST_HUGE) begin
                nx_src[((k % NUM_CHAN) * PER_CH + k / NUM_CHAN) * 64 +: 64] =
                    {20'b0, huge_src_pfn, 12'b0} + ((64'(huge_g) * 64'(MIG_GRP_SIZE) + 64'(k)) << 12);
                nx_dst[((k % NUM_CHAN) * PER_CH + k / NUM_CHAN) * 64 +: 64] =
                    {20'b0, huge_dst_pfn, 12'b0} + ((64'(huge_g) * 64'(MIG_GRP_SIZE) + 64'(k)) << 12);
                nx_vld[(k % NUM_CHAN) * PER_CH + k / NUM_CHAN] = 1'b1;
            end else begin
                pair = slot_data[rd_slot][k / 8][(k % 8) * 64 +: 64];
                nx_src[((k % NUM_CHAN) * PER_CH + k / NUM_CHAN) * 64 +: 64] = {20'b0, pair[31:0], 12'b0};
                nx_dst[((k % NUM_CHAN) * PER_CH + k / NUM_CHAN) * 64 +: 64] = {20'b0, pair[63:32], 12'b0};
                nx_vld[(k % NUM_CHAN) * PER_CH + k / NUM_CHAN] =
                    (pair[31:0] != '0) && slot_ok[rd_slot][k / 8];
            end
        end
    end

    always_ff @(posedge axi4_mm_clk) begin
        if (r_accept) slot_data[r_slot][r_beat] <= hppb_dst_rdata;
    end

    always_ff @(posedge axi4_mm_clk) begin
        if (axi4_mm_rst) begin
            state         <= ST_IDLE;
            fetched_cnt   <= '0;
            grp_ptr       <= '0;
            beat_cnt      <= '0;
            fetch_base    <= '0;
            wr_slot       <= 1'b0;
            rd_slot       <= 1'b0;
            slot_alloc    <= '0;
            slot_mask[0]  <= '0;
            slot_mask[1]  <= '0;
            slot_ok[0]    <= '0;
            slot_ok[1]    <= '0;
            huge_req      <= 1'b0;
            huge_src_pfn  <= '0;
            huge_dst_pfn  <= '0;
            huge_g        <= '0;
            grp_valid     <= 1'b0;
            src_addr      <= '0;
            dst_addr      <= '0;
            pair_vld      <= '0;
            grp_done_cnt  <= '0;
            rresp_err_cnt <= '0;
        end else begin
            state <= next_state;

            if (huge_pg_start && !huge_req) begin
                huge_req     <= 1'b1;
                huge_src_pfn <= huge_pg_addr_pair[31:0];
                huge_dst_pfn <= huge_pg_addr_pair[63:32];
            end
            if ((state == ST_IDLE) && (next_state == ST_HUGE)) begin
                huge_req <= 1'b0;
                huge_g   <= '0;
            end

            // Base is captured so araddr stays stable even if the host rewrites it mid-fetch.
            if ((state == ST_IDLE) && (next_state == ST_FETCH)) begin
                slot_alloc[wr_slot] <= 1'b1;
                slot_mask[wr_slot]  <= '0;
                beat_cnt            <= '0;
                fetch_base          <= addr_pair_buf_pAddr;
            end

            if ((state == ST_FETCH) && hppb_dst_arready) begin
                if (last_beat_acc) begin
                    fetched_cnt <= fetched_cnt + 63'd1;
                    grp_ptr     <= (ptr_inc == {1'b0, ring_groups}) ? 16'd0 : ptr_inc[15:0];
                    wr_slot     <= ~wr_slot;
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end

            if (r_accept) begin
                slot_mask[r_slot][r_beat] <= 1'b1;
                slot_ok[r_slot][r_beat]   <= (hppb_dst_rresp == 2'b00);
                if ((hppb_dst_rresp != 2'b00) && (rresp_err_cnt != '1))
                    rresp_err_cnt <= rresp_err_cnt + 32'd1;
            end

            // Allocation only targets a free slot and release only an occupied one,
            // so both may happen in the same cycle without touching the same slot.
            if (hs) begin
                grp_valid    <= 1'b0;
                grp_done_cnt <= grp_done_cnt + 64'd1;
                if (state == ST_HUGE) begin
                    huge_g <= huge_g + GW'(1);
                end else begin
                    slot_alloc[rd_slot] <= 1'b0;
                    rd_slot             <= ~rd_slot;
                end
            end else if (!grp_valid) begin
                if ((state == ST_HUGE) || (slot_alloc[rd_slot] && slot_full[rd_slot])) begin
                    grp_valid <= 1'b1;
                    src_addr  <= nx_src;
                    dst_addr  <= nx_dst;
                    pair_vld  <= nx_vld;
                end
            end
        end
    end
endmodule

// File: doc/hot_page_addr_fetcher_mc.md
Name: hot_page_addr_fetcher_mc

Overview:
Multi-channel successor to the hot-page address handler.
- Pulls src/dst PFN pair groups from a host ring buffer over an AXI read channel.
- Double-buffers up to two groups with out-of-order beat reassembly.
- Distributes each group's pairs round-robin across NUM_CHAN migration channels through a valid/ready handshake.
- In huge-page mode, synthesises consecutive 4 KiB pair groups arithmetically, with no memory reads.

Parameters:
NUM_CHAN, 2, migration channels; power of two; MIG_GRP_SIZE % NUM_CHAN == 0.
MIG_GRP_SIZE, 16, pairs per group; multiple of 8 (one 512b beat = 8 pairs).
HUGE_PG_PAIRS, 512, 4 KiB pages per huge page; multiple of MIG_GRP_SIZE.
BEATS (localparam), MIG_GRP_SIZE/8, beats per group.
PER_CH (localparam), MIG_GRP_SIZE/NUM_CHAN, pairs per channel per group.

Ports:
axi4_mm_clk  in  1  clock
axi4_mm_rst  in  1  synchronous active-high reset
addr_pair_buf_pAddr  in  64  ring base byte address; 0 = fetching disabled
ring_groups  in  16  ring depth in groups; >=1
addr_pair_vld_cnt  in  64  cumulative groups posted by host; bits [62:0] used
huge_pg_start  in  1  one-cycle request pulse for a huge-page migration
huge_pg_addr_pair  in  64  [31:0] src base PFN, [63:32] dst base PFN
csr_aruser  in  6  AR user field
hppb_dst_arid  out  12  {slot, beat}, zero-extended
hppb_dst_araddr  out  64  byte address
hppb_dst_arvalid  out  1  AR valid
hppb_dst_aruser  out  6  AR user
hppb_dst_arready  in  1  AR ready
hppb_dst_rid  in  12  R id
hppb_dst_rdata  in  512  R data
hppb_dst_rresp  in  2  R response
hppb_dst_rvalid  in  1  R valid
hppb_dst_rready  out  1  always 1
grp_valid  out  1  group available
grp_ready  in  1  consumer accepts group
src_addr  out  64 x NUM_CHAN x PER_CH  src byte addresses
dst_addr  out  64 x NUM_CHAN x PER_CH  dst byte addresses
pair_vld  out  NUM_CHAN x PER_CH  per-pair valid
grp_done_cnt  out  64  groups handed off
rresp_err_cnt  out  32  beats with rresp != 0
busy  out  1  FSM not IDLE, a slot occupied, or huge request pending

Behaviour:
- Reset (sync, high):
  - FSM=IDLE; both slots empty.
  - fetched_cnt=0, grp_ptr=0, all counters=0.
  - arvalid=0, grp_valid=0; all address and pair_vld outputs 0.
  - huge request latch cleared; rready stays 1.
- Pending = addr_pair_vld_cnt[62:0] - fetched_cnt, modulo 2^63.
- FSM states and transitions:
  - IDLE->HUGE: huge latch set, both slots empty, pending==0. Huge has priority over FETCH.
  - IDLE->FETCH: pending!=0, base!=0, a slot free (alloc slot = wr_slot).
  - FETCH: arvalid=1, beat counter b from 0.
    - araddr = base + ((grp_ptr*BEATS + b) << 6); arid = {wr_slot, b}; aruser = csr_aruser.
    - arvalid/araddr held stable until arready.
    - On last beat accept: fetched_cnt++, grp_ptr = (grp_ptr+1 == ring_groups) ? 0 : grp_ptr+1, wr_slot toggles, ->IDLE.
  - HUGE: walks g = 0 .. HUGE_PG_PAIRS/MIG_GRP_SIZE-1, one group per grp handshake.
    - Pair j of group g: src = {20'b0, src_pfn, 12'b0} + ((g*MIG_GRP_SIZE + j) << 12); dst likewise.
    - All pair_vld = 1. After the last handshake ->IDLE.
- huge_pg_start latches into a request flag. A pulse while the flag is already set is ignored.
- R channel:
  - Beat with rid slot s, beat b: data stored in slot s, beat b; beat mask bit b set.
  - Beats may arrive in any order.
  - A beat for a slot not awaiting data (e.g. post-reset stragglers) is dropped.
  - Slot becomes full when all BEATS mask bits are set.
- Pair decode: pair k at bits [64k +: 64] of the group.
  - src PFN = [31:0], dst PFN = [63:32]; address = {20'b0, pfn, 12'b0}.
  - pair_vld = (src PFN != 0) and the beat's rresp == 0.
  - Each rresp != 0 beat increments rresp_err_cnt (saturating).
- Channel mapping: group pair k -> channel k % NUM_CHAN, index k / NUM_CHAN.
- Output handshake:
  - grp_valid asserts the cycle after the oldest slot (rd_slot) becomes full; payload is registered.
  - Payload stable while grp_valid && !grp_ready.
  - On handshake: slot freed, rd_slot toggles, grp_done_cnt++.
  - Groups are delivered strictly in fetch order.
- Simultaneous events:
  - Slot free and new allocation in the same cycle: allowed; the freed slot is reusable next cycle.
  - Doorbell update during FETCH: counted at the next IDLE.
  - base == 0: no new fetch starts; an in-flight FETCH completes.

Test Plan:
- base=0x1000, ring_groups=4, vld_cnt 0->1, rdata pairs k: src=0x100+k, dst=0x200+k -> araddr 0x1000, 0x1040; grp_valid with ch0 idx0 src=0x100000, dst=0x200000; ch1 idx0 src=0x101000; grp_done_cnt=1.
- vld_cnt 0->3, R beats returned in reverse rid order, grp_ready held low 20 cycles -> at most 2 groups fetched before stall; payloads stable; delivered in order; third group's araddr=0x1000+2*128.
- grp_ptr at 3, ring_groups=4, vld_cnt +2 -> second fetch araddr wraps to 0x1000.
- One beat with rresp=2'b10, plus pair 5 with src PFN 0 -> the 8 pairs of that beat and pair 5 have pair_vld=0; rresp_err_cnt=1.
- huge_pg_start with huge_pg_addr_pair={0x300,0x100}, grp_ready=1 -> 32 groups; group 31 pair 15 src=0x100000+511*4096, dst=0x300000+511*4096; then IDLE.
- Reset asserted mid-FETCH with 1 beat outstanding; late R beat arrives after reset -> beat dropped; outputs 0; no grp_valid.
